// File: rtl/spi_slave_byte.sv
// SPI mode-0 byte slave: pins synchronised into sysClk_i, MSB-first RX register
// and a one-entry TX holding buffer feeding the MISO shift register.
module spi_slave_byte #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  IDLE_BYTE   = 8'h00
) (
    input  logic       sysClk_i,
    input  logic       reset_i,
    input  logic       SPI_Clk_i,
    input  logic       SPI_CS_i_n,
    input  logic       SPI_MOSI_i,
    output logic       SPI_MISO_o,
    input  logic       wr_i_n,
    input  logic [7:0] byte_to_send,
    output logic       tx_ready_o,
    output logic       tx_underrun_o,
    output logic [7:0] byte_received_o,
    output logic       rx_valid_o,
    output logic       busy_o
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 3;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;

    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sck_prev_q, sck_prev_d;
    logic                   cs_prev_q, cs_prev_d;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  bitcnt_q, bitcnt_d;
    logic [BYTE_W-1:0] shift_q, shift_d;
    logic [BYTE_W-2:0] rx_q, rx_d;
    logic [BYTE_W-1:0] buf_q, buf_d;
    logic              tx_ready_q, tx_ready_d;
    logic              underrun_q, underrun_d;
    logic [BYTE_W-1:0] byte_rx_q, byte_rx_d;
    logic              rx_valid_q, rx_valid_d;
    logic              busy_q, busy_d;
    logic              miso_q, miso_d;

    logic sck_s, cs_s, mosi_s;
    logic sck_rise, sck_fall, cs_fall, cs_rise;
    logic load;

    assign sck_s  = sck_sync_q[SYNC_STAGES-1];
    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    assign sck_rise = sck_s & ~sck_prev_q;
    assign sck_fall = ~sck_s & sck_prev_q;
    assign cs_fall  = ~cs_s & cs_prev_q;
    assign cs_rise  = cs_s & ~cs_prev_q;

    // Synchroniser shift chains and edge-detect history
    always_comb begin
        sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], SPI_Clk_i};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], SPI_CS_i_n};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], SPI_MOSI_i};
        sck_prev_d  = sck_s;
        cs_prev_d   = cs_s;
    end

    always_comb begin
        state_d    = state_q;
        bitcnt_d   = bitcnt_q;
        shift_d    = shift_q;
        rx_d       = rx_q;
        buf_d      = buf_q;
        tx_ready_d = tx_ready_q;
        byte_rx_d  = byte_rx_q;
        rx_valid_d = 1'b0;
        underrun_d = 1'b0;
        load       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                load     = 1'b1;
                bitcnt_d = '0;
                state_d  = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (cs_rise) begin
                    // Partial byte is dropped; MISO idles low until the next LOAD
                    state_d  = ST_IDLE;
                    bitcnt_d = '0;
                    shift_d  = '0;
                end else if (sck_rise) begin
                    rx_d     = {rx_q[BYTE_W-3:0], mosi_s};
                    bitcnt_d = bitcnt_q + CNT_W'(1);
                    if (bitcnt_q == CNT_W'(7)) begin
                        byte_rx_d  = {rx_q, mosi_s};
                        rx_valid_d = 1'b1;
                    end
                end else if (sck_fall) begin
                    if (bitcnt_q != '0) begin
                        shift_d = {shift_q[BYTE_W-2:0], 1'b0};
                    end else begin
                        load = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Load takes the held byte before this cycle's write can refill the buffer
        if (load) begin
            if (!tx_ready_q) begin
                shift_d    = buf_q;
                tx_ready_d = 1'b1;
            end else begin
                shift_d    = IDLE_BYTE;
                underrun_d = 1'b1;
            end
        end

        if (!wr_i_n && tx_ready_q) begin
            buf_d      = byte_to_send;
            tx_ready_d = 1'b0;
        end

        busy_d = (state_d != ST_IDLE);
        miso_d = ~cs_s & shift_d[BYTE_W-1];
    end

    always_ff @(posedge sysClk_i) begin
        if (reset_i) begin
            sck_sync_q  <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sck_prev_q  <= 1'b0;
            cs_prev_q   <= 1'b1;
            state_q     <= ST_IDLE;
            bitcnt_q    <= '0;
            shift_q     <= '0;
            rx_q        <= '0;
            buf_q       <= '0;
            tx_ready_q  <= 1'b1;
            underrun_q  <= 1'b0;
            byte_rx_q   <= '0;
            rx_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            miso_q      <= 1'b0;
        end else begin
            sck_sync_q  <= sck_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sck_prev_q  <= sck_prev_d;
            cs_prev_q   <= cs_prev_d;
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            shift_q     <= shift_d;
            rx_q        <= rx_d;
            buf_q       <= buf_d;
            tx_ready_q  <= tx_ready_d;
            underrun_q  <= underrun_d;
            byte_rx_q   <= byte_rx_d;
            rx_valid_q  <= rx_valid_d;
            busy_q      <= busy_d;
            miso_q      <= miso_d;
        end
    end

    assign SPI_MISO_o      = miso_q;
    assign tx_ready_o      = tx_ready_q;
    assign tx_underrun_o   = underrun_q;
    assign byte_received_o = byte_rx_q;
    assign rx_valid_o      = rx_valid_q;
    assign busy_o          = busy_q;

endmodule

// File: tb/tb_spi_slave_byte.sv
// Bench for spi_slave_byte: a behavioural SPI master drives frames; expected MISO
// bytes, RX bytes and underrun counts come from the per-frame load/buffer rules.
module tb_spi_slave_byte;

    localparam int HALF = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sck = 1'b0;
    logic       cs_n = 1'b1;
    logic       mosi = 1'b0;
    logic       miso;
    logic       wr_n = 1'b1;
    logic [7:0] tx_byte = 8'h00;
    logic       tx_ready;
    logic       underrun;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int rx_cnt = 0;
    int ur_cnt = 0;
    logic [7:0] rx_log[$];

    always #5 clk = ~clk;

    spi_slave_byte #(.SYNC_STAGES(2), .IDLE_BYTE(8'h00)) dut (
        .sysClk_i       (clk),
        .reset_i        (rst),
        .SPI_Clk_i      (sck),
        .SPI_CS_i_n     (cs_n),
        .SPI_MOSI_i     (mosi),
        .SPI_MISO_o     (miso),
        .wr_i_n         (wr_n),
        .byte_to_send   (tx_byte),
        .tx_ready_o     (tx_ready),
        .tx_underrun_o  (underrun),
        .byte_received_o(rx_byte),
        .rx_valid_o     (rx_valid),
        .busy_o         (busy)
    );

    // Pulse monitor sampled away from the active edge
    always @(negedge clk) begin
        if (rx_valid) begin
            rx_cnt++;
            rx_log.push_back(rx_byte);
        end
        if (underrun) ur_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write_tx(input logic [7:0] b);
        wr_n = 1'b0;
        tx_byte = b;
        cyc(1);
        wr_n = 1'b1;
    endtask

    // One bit: MOSI set in low phase, optional mid-phase write, MISO sampled before the rise
    task automatic sck_bit(input logic d, input bit do_wr, input logic [7:0] wb, output logic m);
        mosi = d;
        cyc(HALF / 2);
        if (do_wr) write_tx(wb);
        else cyc(1);
        cyc(HALF / 2 - 1);
        m = miso;
        sck = 1'b1;
        cyc(HALF);
        sck = 1'b0;
    endtask

    // tx[0]/txv[0]: written before CS falls; tx[k]/txv[k]: written during byte k-1.
    // Every byte boundary (including the last) is a load point, so nb+1 loads occur.
    task automatic frame(input string tag, input int nb, input logic [7:0] mo[4],
                         input logic [7:0] tx[5], input bit txv[5]);
        int rx0 = rx_cnt;
        int ur0 = ur_cnt;
        int exp_ur = 0;
        logic [7:0] got;
        logic [7:0] rxv;
        logic m;
        rx_log.delete();
        if (txv[0]) write_tx(tx[0]);
        cs_n = 1'b0;
        cyc(HALF);
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        chk({tag, "_ready_after_load"}, 32'(tx_ready), 32'd1);
        for (int k = 0; k < nb; k++) begin
            got = 8'h00;
            for (int b = 7; b >= 0; b--) begin
                sck_bit(mo[k][b], (b == 4) && txv[k+1], tx[k+1], m);
                got[b] = m;
            end
            chk($sformatf("%s_miso%0d", tag, k), 32'(got), txv[k] ? 32'(tx[k]) : 32'h00);
        end
        cyc(HALF);
        cs_n = 1'b1;
        cyc(HALF);
        chk({tag, "_rx_count"}, 32'(rx_cnt - rx0), 32'(nb));
        for (int k = 0; k < nb; k++) begin
            rxv = (k < rx_log.size()) ? rx_log[k] : 8'hxx;
            chk($sformatf("%s_rx%0d", tag, k), 32'(rxv), 32'(mo[k]));
        end
        for (int k = 0; k <= nb; k++) if (!txv[k]) exp_ur++;
        chk({tag, "_underruns"}, 32'(ur_cnt - ur0), 32'(exp_ur));
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
        chk({tag, "_idle_ready"}, 32'(tx_ready), 32'd1);
        chk({tag, "_idle_miso"}, 32'(miso), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] mo[4];
        logic [7:0] tx[5];
        bit         txv[5];
        logic       m;
        int         rx0, ur0, nb;

        // Reset values while reset is held
        cyc(3);
        chk("rst_ready", 32'(tx_ready), 32'd1);
        chk("rst_miso", 32'(miso), 32'd0);
        chk("rst_rxbyte", 32'(rx_byte), 32'd0);
        chk("rst_rxvalid", 32'(rx_valid), 32'd0);
        chk("rst_underrun", 32'(underrun), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        cyc(4);

        // Single byte with a held TX byte
        mo = '{8'h3C, 8'h00, 8'h00, 8'h00};
        tx = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00};
        txv = '{1, 0, 0, 0, 0};
        frame("single", 1, mo, tx, txv);
        chk("single_hold", 32'(rx_byte), 32'h3C);

        // Burst: second TX byte written after LOAD
        mo = '{8'hF0, 8'h0F, 8'h00, 8'h00};
        tx = '{8'h11, 8'h5A, 8'h00, 8'h00, 8'h00};
        txv = '{1, 1, 0, 0, 0};
        frame("burst", 2, mo, tx, txv);

        // Empty buffer underrun
        mo = '{8'($urandom), 8'h00, 8'h00, 8'h00};
        txv = '{0, 0, 0, 0, 0};
        frame("underrun", 1, mo, tx, txv);

        // Partial byte then a full transfer with the buffer empty
        rx0 = rx_cnt;
        ur0 = ur_cnt;
        write_tx(8'hC3);
        cs_n = 1'b0;
        cyc(HALF);
        for (int b = 0; b < 4; b++) sck_bit(1'b1, 1'b0, 8'h00, m);
        cyc(HALF);
        cs_n = 1'b1;
        cyc(HALF);
        chk("partial_no_rx", 32'(rx_cnt - rx0), 32'd0);
        chk("partial_no_ur", 32'(ur_cnt - ur0), 32'd0);
        chk("partial_ready", 32'(tx_ready), 32'd1);
        mo = '{8'h81, 8'h00, 8'h00, 8'h00};
        txv = '{0, 0, 0, 0, 0};
        frame("after_partial", 1, mo, tx, txv);

        // Reset after 5 bits of a transfer
        cs_n = 1'b0;
        cyc(HALF);
        rx0 = rx_cnt;
        ur0 = ur_cnt;
        for (int b = 0; b < 5; b++) sck_bit(1'b1, 1'b0, 8'h00, m);
        rst = 1'b1;
        cyc(1);
        cs_n = 1'b1;
        sck = 1'b0;
        cyc(3);
        rst = 1'b0;
        cyc(HALF);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_no_rx", 32'(rx_cnt - rx0), 32'd0);
        chk("midrst_no_ur", 32'(ur_cnt - ur0), 32'd0);
        chk("midrst_miso", 32'(miso), 32'd0);
        chk("midrst_rxbyte", 32'(rx_byte), 32'd0);
        mo = '{8'h96, 8'h00, 8'h00, 8'h00};
        tx = '{8'($urandom), 8'h00, 8'h00, 8'h00, 8'h00};
        txv = '{1, 0, 0, 0, 0};
        frame("post_reset", 1, mo, tx, txv);

        // Randomised bursts with random buffer refills
        for (int f = 0; f < 6; f++) begin
            nb = int'($urandom_range(1, 3));
            for (int k = 0; k < 4; k++) mo[k] = 8'($urandom);
            for (int k = 0; k < 5; k++) begin
                tx[k] = 8'($urandom);
                txv[k] = ($urandom_range(0, 1) == 1);
            end
            frame($sformatf("rand%0d", f), nb, mo, tx, txv);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
